// File: rtl/dmac_sched_if.sv
// Scheduler handshake bundle: per-channel control inputs, grant and beat-completion signals.
// The DUT attaches through the slave modport; the channel/AHB side drives through master.
interface dmac_sched_if;
  logic [3:0] ch_req;
  logic [3:0] ch_en;
  logic [3:0] ch_prio;
  logic       beat_done;
  logic       beat_last;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       start;
  logic [3:0] ch_done;

  modport master (
    output ch_req, ch_en, ch_prio, beat_done, beat_last,
    input  grant, grant_id, busy, start, ch_done
  );

  modport slave (
    input  ch_req, ch_en, ch_prio, beat_done, beat_last,
    output grant, grant_id, busy, start, ch_done
  );
endinterface

// File: rtl/dmac_sched.sv
// DMA transfer scheduler: two-level priority with round-robin inside each level,
// per-grant beat quota, and a one-cycle release gap between bus owners.
module dmac_sched #(
  parameter int unsigned QUOTA = 8,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmac_sched_if.slave   bus
);
  localparam int unsigned NCH = 4;
  localparam int unsigned IDW = 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REL} state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [NCH-1:0] ch_done_q, ch_done_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           start_q, start_d;

  logic [NCH-1:0] elig_c, hi_c, cand_c;
  logic [IDW-1:0] win_c;
  logic           win_vld_c;
  logic [CW:0]    cnt_inc_c;
  logic           abort_c, beat_rel_c;

  // Round-robin winner: scan from ptr+1 upward; the reverse loop lets the nearest candidate win.
  always_comb begin
    logic [IDW-1:0] idx;
    elig_c    = bus.ch_req & bus.ch_en;
    hi_c      = elig_c & bus.ch_prio;
    cand_c    = (|hi_c) ? hi_c : elig_c;
    win_c     = ptr_q;
    win_vld_c = 1'b0;
    idx       = ptr_q;
    for (int k = NCH; k >= 1; k--) begin
      idx = ptr_q + IDW'(k);
      if (cand_c[idx]) begin
        win_c     = idx;
        win_vld_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    ch_done_d  = '0;

    cnt_inc_c  = {1'b0, cnt_q} + (CW+1)'(1);
    abort_c    = ~bus.ch_en[grant_id_q];
    beat_rel_c = bus.beat_done & (bus.beat_last
                                  | (cnt_inc_c == (CW+1)'(QUOTA))
                                  | ~bus.ch_req[grant_id_q]);

    case (state_q)
      S_IDLE, S_REL: begin
        if (win_vld_c) begin
          state_d    = S_BUSY;
          grant_d    = NCH'(1) << win_c;
          grant_id_d = win_c;
          ptr_d      = win_c;
          cnt_d      = '0;
          busy_d     = 1'b1;
          start_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.beat_done) cnt_d = CW'(cnt_inc_c);
        if (abort_c || beat_rel_c) begin
          state_d = S_REL;
          grant_d = '0;
          busy_d  = 1'b0;
          ch_done_d[grant_id_q] = bus.beat_done & bus.beat_last & bus.ch_en[grant_id_q];
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= IDW'(NCH - 1);
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      ch_done_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      ch_done_q  <= ch_done_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.start    = start_q;
  assign bus.ch_done  = ch_done_q;
endmodule

// File: tb/tb_dmac_sched.sv
// Bench for dmac_sched: directed scenarios plus random traffic, every cycle compared
// against a transaction-level ownership model held in plain integers.
module tb_dmac_sched;
  localparam int QUOTA = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmac_sched_if bus ();

  dmac_sched #(.QUOTA(QUOTA), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, whether we are in the release gap, beats taken.
  int   m_owner;     // -1 when nobody owns the bus
  bit   m_gap;
  int   m_ptr;
  int   m_beats;
  int   m_last_id;
  logic [3:0] e_done;
  bit   e_start;

  int   starts[$];
  int   done_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input logic [3:0] en,
                              input logic [3:0] prio, input int ptr);
    logic [3:0] elig;
    bit has_hi;
    elig   = req & en;
    has_hi = (elig & prio) != 4'b0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (elig[c] && (!has_hi || prio[c])) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_gap     = 1'b0;
    m_ptr     = 3;
    m_beats   = 0;
    m_last_id = 0;
    e_done    = '0;
    e_start   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    e_done  = '0;
    e_start = 1'b0;
    if (m_owner < 0) begin
      int w;
      w = pick(bus.ch_req, bus.ch_en, bus.ch_prio, m_ptr);
      m_gap = 1'b0;
      if (w >= 0) begin
        m_owner   = w;
        m_ptr     = w;
        m_last_id = w;
        m_beats   = 0;
        e_start   = 1'b1;
      end
    end else begin
      bit rel;
      rel = !bus.ch_en[m_owner];
      if (bus.beat_done) begin
        m_beats++;
        if (bus.beat_last || m_beats == QUOTA || !bus.ch_req[m_owner]) rel = 1'b1;
        if (bus.beat_last && bus.ch_en[m_owner]) e_done[m_owner] = 1'b1;
      end
      if (rel) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("grant",    32'(bus.grant),    32'(eg));
    check("grant_id", 32'(bus.grant_id), 32'(m_last_id));
    check("busy",     32'(bus.busy),     32'(m_owner >= 0));
    check("start",    32'(bus.start),    32'(e_start));
    check("ch_done",  32'(bus.ch_done),  32'(e_done));
    if (bus.start) starts.push_back(int'(bus.grant_id));
    done_pulses += $countones(bus.ch_done);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [3:0] req, input logic [3:0] en, input logic [3:0] prio,
                        input logic bd, input logic bl);
    bus.ch_req    = req;
    bus.ch_en     = en;
    bus.ch_prio   = prio;
    bus.beat_done = bd;
    bus.beat_last = bl;
  endtask

  // One-cycle reset; outputs must clear asynchronously, before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    check("rst_start", 32'(bus.start), 32'h0);
    check("rst_done",  32'(bus.ch_done), 32'h0);
    check("rst_id",    32'(bus.grant_id), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    done_pulses = 0;
    set_in(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester: grant, full quota, re-grant after the gap.
    set_in(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_start", 32'(bus.start), 32'h1);
    cyc();
    set_in(4'b0001, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (QUOTA) cyc();
    check("t1_quota_rel", 32'(bus.grant), 32'h0);
    set_in(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    check("t1_regrant", 32'(bus.grant), 32'h1);

    // Round-robin with one beat per grant.
    do_reset();
    starts.delete();
    set_in(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    repeat (10) cyc();
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < starts.size()) ? 32'(starts[i]) : 32'hFF, 32'(exp_order[i]));

    // High-priority channel 2 monopolises while requesting, then RR continues from 2.
    set_in(4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (3) cyc();
    starts.delete();
    set_in(4'hF, 4'hF, 4'b0100, 1'b1, 1'b1);
    repeat (12) cyc();
    check("hi_count", 32'(starts.size() >= 4), 32'h1);
    foreach (starts[i]) check("hi_owner", 32'(starts[i]), 32'h2);
    starts.delete();
    set_in(4'b1011, 4'hF, 4'b0100, 1'b1, 1'b1);
    repeat (6) cyc();
    check("after_hi0", (starts.size() > 0) ? 32'(starts[0]) : 32'hFF, 32'h3);
    check("after_hi1", (starts.size() > 1) ? 32'(starts[1]) : 32'hFF, 32'h0);

    // Enable abort of channel 1 after three beats.
    do_reset();
    set_in(4'b0010, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    check("ab_grant", 32'(bus.grant), 32'h2);
    set_in(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (3) cyc();
    set_in(4'hF, 4'b1101, 4'h0, 1'b0, 1'b0);
    cyc();
    check("ab_drop", 32'(bus.grant), 32'h0);
    check("ab_nodone", 32'(bus.ch_done), 32'h0);
    cyc();
    check("ab_next", 32'(bus.grant), 32'h4);

    // Reset mid-burst, then channel 0 wins first.
    do_reset();
    set_in(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    set_in(4'b0001, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (5) cyc();
    set_in(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0);
    do_reset();
    set_in(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    check("mr_first", 32'(bus.grant), 32'h1);

    // Last beat coincides with the quota beat: one release, one ch_done.
    do_reset();
    set_in(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0);
    cyc();
    set_in(4'b0001, 4'hF, 4'h0, 1'b1, 1'b0);
    repeat (QUOTA - 1) cyc();
    set_in(4'b0001, 4'hF, 4'h0, 1'b1, 1'b1);
    done_pulses = 0;
    cyc();
    check("ql_done", 32'(bus.ch_done), 32'h1);
    set_in(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    repeat (4) cyc();
    check("ql_once", 32'(done_pulses), 32'h1);
    set_in(4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    repeat (3) cyc();
    check("idle_beat_busy", 32'(bus.busy), 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] req, en, prio;
      req  = 4'($urandom);
      en   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      prio = ($urandom_range(0, 3) == 0) ? 4'($urandom) : bus.ch_prio;
      set_in(req, en, prio, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmac_sched.md
# dmac_sched

Transfer scheduler for the 4-channel DMA controller. It decides which channel owns the shared AHB master port and for how many beats. It sits between the per-channel control logic (request, enable, priority, last-beat indication) and the AHB master control (beat completion). It provides two-level priority, round-robin within each level, and a per-grant beat quota so that no channel holds the bus indefinitely.

## Interface
Parameters:
- QUOTA, 8: maximum data beats per grant (1..15).
- CW, 4: width of the beat counter; must hold QUOTA.

Ports:
- clk  in  1  system clock (HCLK domain)
- rst  in  1  reset; one clock, asynchronous, active-high
- ch_req  in  4  per-channel "has a beat to move" (enabled channel whose FIFO state allows a transfer)
- ch_en  in  4  per-channel enable from the register block
- ch_prio  in  4  per-channel priority class, 1 = high, 0 = low
- beat_done  in  1  one-cycle pulse: AHB master completed one data beat (HREADY sampled high) for the granted channel
- beat_last  in  1  qualifies beat_done: this beat is the final beat of the channel's block
- grant  out  4  one-hot bus ownership; all zero when idle
- grant_id  out  2  encoded index of the owner; holds its last value when idle
- busy  out  1  high while any grant is asserted
- start  out  1  one-cycle pulse in the first cycle of each new grant
- ch_done  out  4  one-cycle pulse on a channel's bit when its last beat completes

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held.
  - REL: one-cycle release gap.
- Eligible set: ch_req & ch_en.
- Winner selection:
  - Pick from the high-priority subset (eligible & ch_prio) when that subset is non-empty; otherwise from the whole eligible set.
  - Within the chosen subset, use round-robin: search starts at ptr+1 mod 4 and wraps.
  - ptr is the index of the last granted channel.
- IDLE or REL with an eligible channel: register the winner into grant/grant_id, set ptr = winner, clear beat_cnt, pulse start, and go to BUSY.
- IDLE with nothing eligible: stay in IDLE. REL with nothing eligible: go to IDLE.
- BUSY, on each beat_done: beat_cnt increments (CW bits; it never wraps because release happens at QUOTA).
- Release from BUSY to REL, with grant cleared, when any of the following holds:
  - beat_done and beat_last: also pulse ch_done[grant_id].
  - beat_done and beat_cnt+1 == QUOTA.
  - beat_done and ch_req[grant_id] == 0.
  - ch_en[grant_id] == 0 at any cycle: abort. No ch_done pulse; beat_done in the same cycle is still counted.
- Simultaneous release causes: a single release occurs. ch_done fires whenever beat_last is among the causes and the channel is still enabled.
- beat_done while in IDLE or REL is ignored.
- Priority, request and enable changes during BUSY never preempt the owner, except for the ch_en abort above.
- Reset, including mid-burst:
  - state = IDLE, grant = 0, grant_id = 0, busy = 0, start = 0, ch_done = 0, beat_cnt = 0.
  - ptr = 3, so the first grant favours channel 0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Grant latency: eligible request seen in IDLE at cycle N gives grant, busy and start high at N+1. start is low again at N+2.
- Release: a qualifying beat_done at cycle M gives grant = 0 at M+1 (REL), with ch_done pulsing at M+1.
- Re-grant: an eligible request present at M+1 gives the new grant at M+2. There is always at least one idle cycle between owners.
- Abort: ch_en of the owner falling at cycle A gives grant = 0 at A+1.
- Maximum hold time: a grant lasts at most QUOTA beat_done pulses.

## Test plan
- Reset then ch_req = 4'b0001, ch_en = 4'hF, ch_prio = 0 → grant = 0001, grant_id = 0, start pulse one cycle after the request. 8 beat_done pulses → grant drops after the 8th. Channel 0 is re-granted 2 cycles after the 8th beat (no other requester).
- ch_req = 4'hF, ch_prio = 0, every grant released after 1 beat with beat_last = 1 → grant order 0, 1, 2, 3, 0. ch_done pulses on the matching bit each time.
- ch_req = 4'hF, ch_prio = 4'b0100 → channel 2 granted repeatedly while requesting. Clearing ch_req[2] → next grant goes to channel 3, then 0 (round-robin from ptr = 2).
- During channel 1 BUSY after 3 beats, drop ch_en[1] → grant = 0 next cycle, no ch_done. The next eligible channel is granted the cycle after.
- Assert rst for one cycle mid-burst (beat_cnt = 5) → all outputs 0 immediately. After release, ch_req = 4'hF → channel 0 granted first.
- beat_done with beat_last = 1 on the QUOTA-th beat → exactly one release and exactly one ch_done pulse. beat_done while IDLE → no output change.
